// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Byte-stream program loader. Receives a framed byte stream
//               (LEN_HI, LEN_LO, N x 4 data bytes MSB first, CHK) over a
//               valid/ready handshake and writes each big-endian 32-bit word
//               to consecutive CPU load addresses starting at 0. It holds the
//               CPU in reset during the load. If the XOR checksum matches, it
//               releases the CPU.
// Optional    : PROG_LOADER_DATA_SEG_EN - LEN_HI[7] selects the data segment
//               (write_data) instead of the instruction segment.
// Ports       : clk, rst (async, active high)
//               start               - one-cycle pulse, begins a load
//               byte_in/byte_valid  - stream byte and its valid
//               byte_ready          - loader accepts a byte this cycle
//               cpu_rst             - CPU reset, low only after a good load
//               address/inst_data   - CPU load address and word
//               write_instruction   - instruction-memory write strobe
//               write_data          - data-memory write strobe
//               busy/done/error     - load status
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024,
    parameter int WR_HOLD   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       inst_data,
    output logic              write_instruction,
    output logic              write_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int LEN_W  = 11;
    localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHECK  = 3'd5,
        S_RUN    = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         data_q;
    logic [7:0]          chk_q;
    logic [7:0]          hi_q;
    logic [1:0]          byte_cnt_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    word_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic                cpu_rst_q;
    logic                wr_inst_q;
`ifdef PROG_LOADER_DATA_SEG_EN
    logic                wr_data_q;
    logic                seg_q;
`endif

    logic                w_xfer;
    logic [LEN_W-1:0]    w_len;
    logic                w_len_bad;
    logic                w_too_long;
    logic                w_last_word;
    logic                w_hold_end;

    assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
    assign w_xfer     = byte_valid && byte_ready;

    // Word count is only complete once LEN_LO is on the bus.
    assign w_len      = {hi_q[2:0], byte_in};
`ifdef PROG_LOADER_DATA_SEG_EN
    assign w_len_bad  = (hi_q[6:3] != 4'd0);
`else
    assign w_len_bad  = (hi_q[7:3] != 5'd0);
`endif
    assign w_too_long  = ({21'd0, w_len} > 32'(MAX_WORDS));
    assign w_last_word = ((word_q + LEN_W'(1)) == len_q);
    assign w_hold_end  = (hold_q == HOLD_W'(WR_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            chk_q      <= '0;
            hi_q       <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            word_q     <= '0;
            hold_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_rst_q  <= 1'b1;
            wr_inst_q  <= 1'b0;
`ifdef PROG_LOADER_DATA_SEG_EN
            wr_data_q  <= 1'b0;
            seg_q      <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle: they are set on entry to WRITE only.
            wr_inst_q <= 1'b0;
`ifdef PROG_LOADER_DATA_SEG_EN
            wr_data_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE, S_RUN, S_ERR: begin
                    if (start) begin
                        state_q    <= S_LEN_HI;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        addr_q     <= '0;
                        chk_q      <= '0;
                        byte_cnt_q <= '0;
                        word_q     <= '0;
                        busy_q     <= 1'b1;
                        cpu_rst_q  <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        hi_q    <= byte_in;
                        chk_q   <= chk_q ^ byte_in;
                        state_q <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        chk_q <= chk_q ^ byte_in;
                        len_q <= w_len;
`ifdef PROG_LOADER_DATA_SEG_EN
                        seg_q <= hi_q[7];
`endif
                        if (w_len_bad || w_too_long) begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (w_len == '0) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q    <= S_DATA;
                            byte_cnt_q <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        data_q     <= {data_q[23:0], byte_in};
                        chk_q      <= chk_q ^ byte_in;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q <= S_WRITE;
                            hold_q  <= '0;
`ifdef PROG_LOADER_DATA_SEG_EN
                            if (seg_q) begin
                                wr_data_q <= 1'b1;
                            end else begin
                                wr_inst_q <= 1'b1;
                            end
`else
                            wr_inst_q <= 1'b1;
`endif
                        end
                    end
                end
                S_WRITE: begin
                    // address/inst_data stay frozen for WR_HOLD cycles.
                    if (w_hold_end) begin
                        if (w_last_word) begin
                            state_q <= S_CHECK;
                        end else begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            word_q  <= word_q + LEN_W'(1);
                            state_q <= S_DATA;
                        end
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_xfer) begin
                        busy_q <= 1'b0;
                        if (byte_in == chk_q) begin
                            state_q   <= S_RUN;
                            cpu_rst_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_rst           = cpu_rst_q;
    assign address           = addr_q;
    assign inst_data         = data_q;
    assign write_instruction = wr_inst_q;
`ifdef PROG_LOADER_DATA_SEG_EN
    assign write_data        = wr_data_q;
`else
    assign write_data        = 1'b0;
`endif
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;

endmodule
`default_nettype wire
